// File: rtl/fir_pkg.sv
// Shared constants, state encoding and default coefficient table for the
// time-multiplexed FIR tap sequencer.
package fir_pkg;

  localparam int NTAPS  = 6;
  localparam int DATA_W = 8;
  localparam int COEF_W = 4;
  localparam int ACC_W  = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ADDR_W = $clog2(NTAPS);
  localparam int K_W    = $clog2(NTAPS + 1);

  // Packed coefficient table, c[0] in the least significant nibble: {1,2,3,3,2,1}.
  localparam logic [NTAPS*COEF_W-1:0] FIR_DEFAULT_COEF = 24'h123321;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  function automatic logic signed [COEF_W-1:0] default_coef(input int idx);
    return FIR_DEFAULT_COEF[idx*COEF_W +: COEF_W];
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed multiply-accumulate. The product is registered before it is
// added, so each accumulation lands one cycle after its operands are issued.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic        [DATA_W-1:0] acc_lo
);

  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_vld_q;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod_d = PROD_W'(a) * PROD_W'(b);
  assign acc_lo = acc_q[DATA_W-1:0];

  // Product pipeline stage and sign-extended accumulation; clear starts a new sum.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= en;
      if (prod_vld_q)
        acc_q <= acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: one sample per handshake, one tap per cycle
// through a shared MAC, result held until the sink accepts it.
// Optional feature macro: FIR_COEF_CFG_EN (writable coefficient registers).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | ready for a sample; coefficient writes land here
//   ST_MAC  | issue tap k (k < NTAPS); k == NTAPS drains the product stage
//   ST_OUT  | result presented on out_valid/result until out_ready
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] result,
  output logic                     busy
`ifdef FIR_COEF_CFG_EN
  ,
  input  logic                     cfg_we,
  input  logic        [ADDR_W-1:0] cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic                     cfg_busy
`endif
);

  fir_state_e               state_q, state_d;
  logic        [K_W-1:0]    k_q;
  logic signed [DATA_W-1:0] x_q  [NTAPS];
  logic signed [COEF_W-1:0] coef [NTAPS];
  logic        [ADDR_W-1:0] tap_idx;
  logic                     accept;
  logic                     last_k;
  logic                     mac_en;
  logic        [DATA_W-1:0] acc_lo;

  assign accept  = in_valid && in_ready;
  assign last_k  = (k_q == K_W'(NTAPS));
  // The drain cycle (k == NTAPS) has no tap; park the mux on tap 0.
  assign tap_idx = last_k ? '0 : ADDR_W'(k_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mac_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = ST_MAC;
      end
      ST_MAC: begin
        busy   = 1'b1;
        mac_en = !last_k;
        if (last_k)
          state_d = ST_OUT;
      end
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tap index: restarts on accept, walks through the taps plus one drain cycle.
  always_ff @(posedge clk) begin
    if (reset)
      k_q <= '0;
    else if (accept)
      k_q <= '0;
    else if (state_q == ST_MAC && !last_k)
      k_q <= k_q + 1'b1;
  end

  // Delay line shifts only when a sample is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++)
        x_q[i] <= '0;
    end else if (accept) begin
      for (int i = NTAPS - 1; i > 0; i--)
        x_q[i] <= x_q[i-1];
      x_q[0] <= sample;
    end
  end

`ifdef FIR_COEF_CFG_EN
  // Coefficient registers; writes are only honoured while idle so a running sum never mixes sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++)
        coef[i] <= default_coef(i);
    end else if (cfg_we && state_q == ST_IDLE && cfg_addr < ADDR_W'(NTAPS)) begin
      coef[cfg_addr] <= cfg_data;
    end
  end

  assign cfg_busy = busy;
`else
  // Fixed coefficient set.
  always_comb begin
    for (int i = 0; i < NTAPS; i++)
      coef[i] = default_coef(i);
  end
`endif

  fir_mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .en     (mac_en),
    .a      (x_q[tap_idx]),
    .b      (coef[tap_idx]),
    .acc_lo (acc_lo)
  );

  assign result = (state_q == ST_OUT) ? $signed(acc_lo) : '0;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench for fir_tap_sequencer.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] sample;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] result;
  logic                     busy;
`ifdef FIR_COEF_CFG_EN
  logic                     cfg_we;
  logic        [ADDR_W-1:0] cfg_addr;
  logic signed [COEF_W-1:0] cfg_data;
  logic                     cfg_busy;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sample    (sample),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef FIR_COEF_CFG_EN
    ,
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sample    = '0;
`ifdef FIR_COEF_CFG_EN
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Offer one sample, expect its result 7 edges after the accept edge, optionally
  // hold off the sink for 'hold' cycles, then take the result.
  task automatic feed(input string tag, input logic signed [7:0] s,
                      input logic signed [7:0] exp, input int hold, input bit mac_wr);
    int lat;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    sample   = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sample   = '0;
    lat = 0;
`ifdef FIR_COEF_CFG_EN
    if (mac_wr) begin
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_data = 4'sd7;
      chk({tag, ".cfg_busy"}, 32'(cfg_busy), 32'd1);
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      lat = 1;
    end
`else
    if (mac_wr) $display("note: %s mac write skipped in fixed-coefficient build", tag);
`endif
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd7);
    chk({tag, ".result"}, 32'(result), 32'(exp));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      sample   = 8'sd99;
      @(posedge clk);
      #1;
      chk({tag, ".hold_result"}, 32'(result), 32'(exp));
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    sample    = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);

    // Sink ready with no result pending changes nothing.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_ordy.in_ready", 32'(in_ready), 32'd1);
    chk("idle_ordy.out_valid", 32'(out_valid), 32'd0);

    // Impulse response reproduces the coefficients.
    feed("imp0", 8'sd1, 8'sd1, 0, 1'b0);
    feed("imp1", 8'sd0, 8'sd2, 0, 1'b0);
    feed("imp2", 8'sd0, 8'sd3, 0, 1'b0);
    feed("imp3", 8'sd0, 8'sd3, 0, 1'b0);
    feed("imp4", 8'sd0, 8'sd2, 0, 1'b0);
    feed("imp5", 8'sd0, 8'sd1, 0, 1'b0);

    // Step of 10, with sink backpressure on the third result.
    do_reset();
    feed("step0", 8'sd10, 8'sd10, 0, 1'b0);
    feed("step1", 8'sd10, 8'sd30, 0, 1'b0);
    feed("step2", 8'sd10, 8'sd60, 5, 1'b0);
    feed("step3", 8'sd10, 8'sd90, 0, 1'b0);
    feed("step4", 8'sd10, 8'sd110, 0, 1'b0);
    feed("step5", 8'sd10, 8'sd120, 0, 1'b0);

    // Step of 100: sums 100,300,600,900,1100,1200 wrapped to 8 bits.
    do_reset();
    feed("wrap0", 8'sd100, 8'sd100, 0, 1'b0);
    feed("wrap1", 8'sd100, 8'sd44, 0, 1'b0);
    feed("wrap2", 8'sd100, 8'sd88, 0, 1'b0);
    feed("wrap3", 8'sd100, -8'sd124, 0, 1'b0);
    feed("wrap4", 8'sd100, 8'sd76, 0, 1'b0);
    feed("wrap5", 8'sd100, -8'sd80, 0, 1'b0);

    // Reset during MAC tap 3 discards the sum and clears the delay line.
    do_reset();
    sample   = 8'sd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.busy_before", 32'(busy), 32'd1);
    do_reset();
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    feed("rimp0", 8'sd1, 8'sd1, 0, 1'b0);
    feed("rimp1", 8'sd0, 8'sd2, 0, 1'b0);
    feed("rimp2", 8'sd0, 8'sd3, 0, 1'b0);
    feed("rimp3", 8'sd0, 8'sd3, 0, 1'b0);
    feed("rimp4", 8'sd0, 8'sd2, 0, 1'b0);
    feed("rimp5", 8'sd0, 8'sd1, 0, 1'b0);

`ifdef FIR_COEF_CFG_EN
    // All-ones coefficients, then a step of 5; a write during MAC must be dropped.
    do_reset();
    chk("cfg.idle_busy", 32'(cfg_busy), 32'd0);
    for (int i = 0; i < NTAPS; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = ADDR_W'(i);
      cfg_data = 4'sd1;
      @(posedge clk);
      #1;
    end
    cfg_we = 1'b0;
    feed("cfg0", 8'sd5, 8'sd5, 0, 1'b1);
    feed("cfg1", 8'sd5, 8'sd10, 0, 1'b0);
    feed("cfg2", 8'sd5, 8'sd15, 0, 1'b0);
    feed("cfg3", 8'sd5, 8'sd20, 0, 1'b0);
    feed("cfg4", 8'sd5, 8'sd25, 0, 1'b0);
    feed("cfg5", 8'sd5, 8'sd30, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
